// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the shared 32-bit alu.
// Holds the alu control codes used by the alu and by the requesters.
package alu_share_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0100,
    ALU_AND = 4'b0001,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0010,
    ALU_LUI = 4'b0110,
    ALU_SLL = 4'b0011,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1111
  } alu_op_e;

  localparam int unsigned DW = 32;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester and response channels of the shared-alu arbiter.
// The master side is the set of requesters plus the response consumer.
interface alu_share_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*4-1:0]  req_aluc;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_s;
  logic               rsp_z;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_aluc, rsp_ready,
    input  req_ready, rsp_valid, rsp_s, rsp_z, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_aluc, rsp_ready,
    output req_ready, rsp_valid, rsp_s, rsp_z, rsp_id
  );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit alu: s = f(a, b, aluc), z = (s == 0).
// Shift amount is the whole of a; shifted operand is b.
module alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] s,
  output logic        z
);

  logic big_shift;

  always_comb begin
    s         = '0;
    big_shift = (a >= 32'd32);
    // Bit 3 is a don't-care except for the three shift codes (low bits 2'b11).
    if (aluc[1:0] != 2'b11) begin
      case (alu_op_e'({1'b0, aluc[2:0]}))
        ALU_ADD: s = a + b;
        ALU_SUB: s = a - b;
        ALU_AND: s = a & b;
        ALU_OR:  s = a | b;
        ALU_XOR: s = a ^ b;
        ALU_LUI: s = {b[15:0], 16'h0000};
        default: s = '0;
      endcase
    end else begin
      case (alu_op_e'(aluc))
        ALU_SLL: s = big_shift ? '0 : (b << a[4:0]);
        ALU_SRL: s = big_shift ? '0 : (b >> a[4:0]);
        ALU_SRA: s = big_shift ? {32{b[31]}} : 32'($signed(b) >>> a[4:0]);
        default: s = '0;
      endcase
    end
    z = (s == '0);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one alu among NREQ requesters, with a single
// registered, id-tagged response channel that supports backpressure.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic                clock,
  input  logic                resetn,
  alu_share_arbiter_if.slave  bus
);

  logic [IDW-1:0]  last_grant;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;
  logic            found;
  logic            free;
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  logic [3:0]      aluc_sel;
  logic [31:0]     alu_s;
  logic            alu_z;

  // Search starts just after the last winner; rotate, pick first, unrotate in one pass.
  always_comb begin
    free  = !bus.rsp_valid || bus.rsp_ready;
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(last_grant) + k) % NREQ;
      if (!found && free && resetn && bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx[IDW-1:0];
      end
    end
  end

  assign bus.req_ready = grant;

  always_comb begin
    a_sel    = bus.req_a[32*win +: 32];
    b_sel    = bus.req_b[32*win +: 32];
    aluc_sel = bus.req_aluc[4*win +: 4];
  end

  alu u_alu (
    .a    (a_sel),
    .b    (b_sel),
    .aluc (aluc_sel),
    .s    (alu_s),
    .z    (alu_z)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_s     <= '0;
      bus.rsp_z     <= 1'b0;
      bus.rsp_id    <= '0;
      last_grant    <= IDW'(NREQ - 1);
    end else if (found) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_s     <= alu_s;
      bus.rsp_z     <= alu_z;
      bus.rsp_id    <= win;
      last_grant    <= win;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic clock;
  logic resetn;

  alu_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference alu expressed as plain arithmetic on the operation meaning.
  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    if (op == 4'b0011) begin
      if (a >= 32) return 32'd0;
      p = {32'd0, b} * (64'd1 << a);
      return p[31:0];
    end
    if (op == 4'b0111) return (a >= 32) ? 32'd0 : b / (32'd1 << a);
    if (op == 4'b1111) begin
      if (a >= 32) return b[31] ? 32'hFFFF_FFFF : 32'd0;
      return b[31] ? ~((~b) / (32'd1 << a)) : b / (32'd1 << a);
    end
    if (op == 4'b1011) return 32'd0;
    case (op[2:0])
      3'd0: return a + b;
      3'd4: return a - b;
      3'd1: return a & b;
      3'd5: return a | b;
      3'd2: return a ^ b;
      3'd6: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  // Model state
  logic            m_valid;
  logic [31:0]     m_s;
  logic            m_z;
  int              m_id;
  int              m_last;
  logic [NREQ-1:0] acc;

  initial begin
    m_valid = 1'b0; m_s = '0; m_z = 1'b0; m_id = 0; m_last = NREQ - 1; acc = '0;
  end

  always @(negedge clock) begin
    logic [NREQ-1:0] exp_g;
    int w;
    exp_g = '0;
    w     = 0;
    if (!resetn) begin
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_s", bus.rsp_s, 32'd0);
      check("rst_z", 32'(bus.rsp_z), 32'd0);
      check("rst_id", 32'(bus.rsp_id), 32'd0);
      m_valid = 1'b0; m_s = '0; m_z = 1'b0; m_id = 0; m_last = NREQ - 1;
      acc = '0;
    end else begin
      check("m_valid", 32'(bus.rsp_valid), 32'(m_valid));
      check("m_s", bus.rsp_s, m_s);
      check("m_z", 32'(bus.rsp_z), 32'(m_z));
      check("m_id", 32'(bus.rsp_id), 32'(m_id));
      if (!m_valid || bus.rsp_ready) begin
        for (int k = 1; k <= NREQ; k++) begin
          int p;
          p = (m_last + k) % NREQ;
          if (exp_g == '0 && bus.req_valid[p]) begin
            exp_g[p] = 1'b1;
            w        = p;
          end
        end
      end
      check("m_ready", 32'(bus.req_ready), 32'(exp_g));
      if (exp_g != '0) begin
        m_s     = m_alu(bus.req_aluc[4*w +: 4], bus.req_a[32*w +: 32], bus.req_b[32*w +: 32]);
        m_z     = (m_s == 32'd0);
        m_id    = w;
        m_last  = w;
        m_valid = 1'b1;
      end else if (bus.rsp_ready) begin
        m_valid = 1'b0;
      end
      acc = exp_g;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]        = v;
    bus.req_aluc[4*i +: 4]  = op;
    bus.req_a[32*i +: 32]   = a;
    bus.req_b[32*i +: 32]   = b;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
  } vec_t;

  initial begin
    vec_t shv[4];
    shv[0] = '{ALU_SRA, 32'd4,  32'h8000_0000, 32'hF800_0000};
    shv[1] = '{ALU_SRL, 32'd4,  32'h8000_0000, 32'h0800_0000};
    shv[2] = '{ALU_SLL, 32'd32, 32'h8000_0000, 32'h0000_0000};
    shv[3] = '{ALU_LUI, 32'd0,  32'h0000_1234, 32'h1234_0000};

    resetn        = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_aluc  = '0;
    bus.rsp_ready = 1'b1;
    #1 resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;

    // Single ADD from req0
    set_req(0, 1, ALU_ADD, 32'd5, 32'd3);
    #1 check("t1_ready", 32'(bus.req_ready), 32'd1);
    cyc();
    set_req(0, 0, ALU_ADD, 32'd0, 32'd0);
    check("t1_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_s", bus.rsp_s, 32'd8);
    check("t1_z", 32'(bus.rsp_z), 32'd0);
    check("t1_id", 32'(bus.rsp_id), 32'd0);

    // Alternating grants under continuous demand
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    set_req(0, 1, ALU_SUB, 32'd7, 32'd7);
    set_req(1, 1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    for (int k = 0; k < 4; k++) begin
      #1 check("t2_ready", 32'(bus.req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
      cyc();
      check("t2_valid", 32'(bus.rsp_valid), 32'd1);
      check("t2_s", bus.rsp_s, (k % 2 == 1) ? 32'h0000_00FF : 32'd0);
      check("t2_z", 32'(bus.rsp_z), (k % 2 == 1) ? 32'd0 : 32'd1);
    end

    // Backpressure holds the response from req1 and blocks grants
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("t3_ready", 32'(bus.req_ready), 32'd0);
      cyc();
      check("t3_valid", 32'(bus.rsp_valid), 32'd1);
      check("t3_s", bus.rsp_s, 32'h0000_00FF);
      check("t3_id", 32'(bus.rsp_id), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    #1 check("t3_next", 32'(bus.req_ready), 32'd1);
    cyc();
    set_req(0, 0, ALU_ADD, 32'd0, 32'd0);
    check("t3_id0", 32'(bus.rsp_id), 32'd0);
    #1 check("t3_req1", 32'(bus.req_ready), 32'd2);
    cyc();
    set_req(1, 0, ALU_ADD, 32'd0, 32'd0);

    // Shift and LUI vectors through req0
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1, shv[k].op, shv[k].a, shv[k].b);
      cyc();
      set_req(0, 0, ALU_ADD, 32'd0, 32'd0);
      check("t4_s", bus.rsp_s, shv[k].s);
      check("t4_z", 32'(bus.rsp_z), 32'(shv[k].s == 32'd0));
    end

    // Reset while a response is held and both requesters wait
    set_req(0, 1, ALU_ADD, 32'd1, 32'd2);
    set_req(1, 1, ALU_XOR, 32'hFF, 32'h0F);
    bus.rsp_ready = 1'b0;
    cyc();
    check("t5_pre", 32'(bus.rsp_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check("t5_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_s", bus.rsp_s, 32'd0);
    check("t5_id", 32'(bus.rsp_id), 32'd0);
    check("t5_ready", 32'(bus.req_ready), 32'd0);
    cyc();
    resetn = 1'b1;
    bus.rsp_ready = 1'b1;
    #1 check("t5_first", 32'(bus.req_ready), 32'd1);
    cyc();
    set_req(0, 0, ALU_ADD, 32'd0, 32'd0);
    check("t5_s3", bus.rsp_s, 32'd3);

    // Idle gap does not rotate priority
    #1 check("t6_req1", 32'(bus.req_ready), 32'd2);
    cyc();
    set_req(1, 0, ALU_ADD, 32'd0, 32'd0);
    check("t6_id1", 32'(bus.rsp_id), 32'd1);
    repeat (5) cyc();
    check("t6_idle", 32'(bus.rsp_valid), 32'd0);
    set_req(0, 1, ALU_AND, 32'hF0F0, 32'hFF00);
    set_req(1, 1, ALU_ADD, 32'd9, 32'd9);
    #1 check("t6_grant0", 32'(bus.req_ready), 32'd1);
    cyc();
    check("t6_s", bus.rsp_s, 32'h0000_F000);

    // Random traffic; requesters keep payload until accepted
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          logic [31:0] ra;
          ra = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
          set_req(i, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ra, $urandom());
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      resetn = ($urandom_range(0, 199) != 0);
      cyc();
    end
    resetn = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
